// File: rtl/dbg_pkg.sv
// Shared types for the commit trace path between writeback and the simulation debugger.
package dbg_pkg;

   localparam int unsigned DBG_XLEN = 32;

   // 104-bit retired-instruction record as stored in the trace queue
   typedef struct packed {
      logic [DBG_XLEN-1:0] pc;
      logic [DBG_XLEN-1:0] inst;
      logic                gpr_wen;
      logic [4:0]          gpr_waddr;
      logic [DBG_XLEN-1:0] gpr_wdata;
      logic                brk;
      logic                ivd;
   } commit_rec_t;

endpackage

// File: rtl/commit_trace_queue_if.sv
// Writeback-to-trace-queue record handshake.
interface commit_trace_queue_if;
   import dbg_pkg::*;

   logic                wb_valid;
   logic                wb_ready;
   logic [DBG_XLEN-1:0] wb_pc;
   logic [DBG_XLEN-1:0] wb_inst;
   logic                wb_gpr_wen;
   logic [4:0]          wb_gpr_waddr;
   logic [DBG_XLEN-1:0] wb_gpr_wdata;
   logic                wb_brk;
   logic                wb_ivd;

   modport master (
      output wb_valid, wb_pc, wb_inst, wb_gpr_wen, wb_gpr_waddr, wb_gpr_wdata, wb_brk, wb_ivd,
      input  wb_ready
   );

   modport slave (
      input  wb_valid, wb_pc, wb_inst, wb_gpr_wen, wb_gpr_waddr, wb_gpr_wdata, wb_brk, wb_ivd,
      output wb_ready
   );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; push ignored when full, pop ignored when empty.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

   assign dout  = mem[rd_ptr[AW-1:0]];
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/commit_trace_queue.sv
// Buffers retired records from WBU and replays them one per cycle to the debugger,
// stopping intake for good once a break or invalid-instruction record is accepted.
module commit_trace_queue
   import dbg_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   commit_trace_queue_if.slave       wb,
   input  logic                      drain_en,
   output logic [DBG_XLEN-1:0]       dbg_pc,
   output logic [DBG_XLEN-1:0]       dbg_inst,
   output logic                      dbg_done,
   output logic                      dbg_gpr_wen,
   output logic [DBG_XLEN-1:0]       dbg_gpr_waddr,
   output logic [DBG_XLEN-1:0]       dbg_gpr_wdata,
   output logic                      dbg_brk,
   output logic                      dbg_ivd,
   output logic                      halted,
   output logic [$clog2(DEPTH):0]    count
);

   commit_rec_t in_rec;
   commit_rec_t head_rec;
   logic        full;
   logic        empty;
   logic        push;
   logic        pop;

   // Ready is a function of registered state only, so a same-cycle pop never frees a slot early
   assign wb.wb_ready = !halted && !full;
   assign push        = wb.wb_valid && wb.wb_ready;
   assign pop         = drain_en && !empty;

   always_comb begin
      in_rec           = '0;
      in_rec.pc        = wb.wb_pc;
      in_rec.inst      = wb.wb_inst;
      in_rec.gpr_wen   = wb.wb_gpr_wen && (wb.wb_gpr_waddr != '0);
      in_rec.gpr_waddr = wb.wb_gpr_waddr;
      in_rec.gpr_wdata = wb.wb_gpr_wdata;
      in_rec.brk       = wb.wb_brk;
      in_rec.ivd       = wb.wb_ivd;
   end

   sync_fifo #(
      .WIDTH ($bits(commit_rec_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (in_rec),
      .dout  (head_rec),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   always_ff @(posedge clk) begin
      if (reset)
         halted <= 1'b0;
      else if (push && (wb.wb_brk || wb.wb_ivd))
         halted <= 1'b1;
   end

   // Strobes last one cycle per pop; data fields hold until the next pop
   always_ff @(posedge clk) begin
      if (reset) begin
         dbg_pc        <= '0;
         dbg_inst      <= '0;
         dbg_done      <= 1'b0;
         dbg_gpr_wen   <= 1'b0;
         dbg_gpr_waddr <= '0;
         dbg_gpr_wdata <= '0;
         dbg_brk       <= 1'b0;
         dbg_ivd       <= 1'b0;
      end else begin
         dbg_done    <= pop;
         dbg_gpr_wen <= pop && head_rec.gpr_wen;
         dbg_brk     <= pop && head_rec.brk;
         dbg_ivd     <= pop && head_rec.ivd;
         if (pop) begin
            dbg_pc        <= head_rec.pc;
            dbg_inst      <= head_rec.inst;
            dbg_gpr_waddr <= DBG_XLEN'(head_rec.gpr_waddr);
            dbg_gpr_wdata <= head_rec.gpr_wdata;
         end
      end
   end

endmodule

// File: tb/tb_commit_trace_queue.sv
// Directed self-checking bench for commit_trace_queue with DEPTH=4.
module tb_commit_trace_queue;
   import dbg_pkg::*;

   logic        clk;
   logic        reset;
   logic        drain_en;
   logic [31:0] dbg_pc;
   logic [31:0] dbg_inst;
   logic        dbg_done;
   logic        dbg_gpr_wen;
   logic [31:0] dbg_gpr_waddr;
   logic [31:0] dbg_gpr_wdata;
   logic        dbg_brk;
   logic        dbg_ivd;
   logic        halted;
   logic [2:0]  count;

   int unsigned n_cmp;
   int unsigned n_bad;

   commit_trace_queue_if wbif ();

   commit_trace_queue #(.DEPTH(4)) dut (
      .clk           (clk),
      .reset         (reset),
      .wb            (wbif.slave),
      .drain_en      (drain_en),
      .dbg_pc        (dbg_pc),
      .dbg_inst      (dbg_inst),
      .dbg_done      (dbg_done),
      .dbg_gpr_wen   (dbg_gpr_wen),
      .dbg_gpr_waddr (dbg_gpr_waddr),
      .dbg_gpr_wdata (dbg_gpr_wdata),
      .dbg_brk       (dbg_brk),
      .dbg_ivd       (dbg_ivd),
      .halted        (halted),
      .count         (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic valid, input logic [31:0] pc, input logic [31:0] inst,
                        input logic wen, input logic [4:0] waddr, input logic [31:0] wdata,
                        input logic brk, input logic ivd);
      wbif.wb_valid     = valid;
      wbif.wb_pc        = pc;
      wbif.wb_inst      = inst;
      wbif.wb_gpr_wen   = wen;
      wbif.wb_gpr_waddr = waddr;
      wbif.wb_gpr_wdata = wdata;
      wbif.wb_brk       = brk;
      wbif.wb_ivd       = ivd;
   endtask

   initial begin
      n_cmp    = 0;
      n_bad    = 0;
      reset    = 1'b1;
      drain_en = 1'b0;
      drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
      tick();
      tick();
      reset = 1'b0;

      // reset state
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_ready", 32'(wbif.wb_ready), 32'd1);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_done", 32'(dbg_done), 32'd0);
      chk("rst_pc", dbg_pc, 32'd0);

      // single record, 2-cycle latency
      drain_en = 1'b1;
      drive(1'b1, 32'h8000_0000, 32'h0010_0093, 1'b1, 5'd1, 32'd1, 1'b0, 1'b0);
      tick();
      drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
      chk("lat_e1_count", 32'(count), 32'd1);
      chk("lat_e1_done", 32'(dbg_done), 32'd0);
      tick();
      chk("lat_done", 32'(dbg_done), 32'd1);
      chk("lat_wen", 32'(dbg_gpr_wen), 32'd1);
      chk("lat_waddr", dbg_gpr_waddr, 32'd1);
      chk("lat_wdata", dbg_gpr_wdata, 32'd1);
      chk("lat_pc", dbg_pc, 32'h8000_0000);
      chk("lat_inst", dbg_inst, 32'h0010_0093);
      chk("lat_count", 32'(count), 32'd0);
      tick();
      chk("lat_done_fall", 32'(dbg_done), 32'd0);
      chk("lat_wen_fall", 32'(dbg_gpr_wen), 32'd0);
      chk("lat_pc_hold", dbg_pc, 32'h8000_0000);

      // fill with draining paused, fifth record stalls
      drain_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'h100 + 32'(i) * 4, 32'h13, 1'b1, 5'(i + 1), 32'(i + 10), 1'b0, 1'b0);
         tick();
      end
      chk("fill_count", 32'(count), 32'd4);
      chk("fill_ready", 32'(wbif.wb_ready), 32'd0);
      drive(1'b1, 32'h110, 32'h13, 1'b1, 5'd5, 32'd14, 1'b0, 1'b0);
      tick();
      chk("stall_count", 32'(count), 32'd4);
      chk("stall_done", 32'(dbg_done), 32'd0);
      drain_en = 1'b1;
      tick();
      chk("drain0_pc", dbg_pc, 32'h100);
      chk("drain0_wdata", dbg_gpr_wdata, 32'd10);
      chk("drain0_count", 32'(count), 32'd3);
      chk("drain0_ready", 32'(wbif.wb_ready), 32'd1);
      tick();
      drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
      chk("drain1_pc", dbg_pc, 32'h104);
      chk("drain1_waddr", dbg_gpr_waddr, 32'd2);
      chk("drain1_count", 32'(count), 32'd3);
      tick();
      chk("drain2_pc", dbg_pc, 32'h108);
      chk("drain2_count", 32'(count), 32'd2);
      tick();
      chk("drain3_pc", dbg_pc, 32'h10C);
      chk("drain3_count", 32'(count), 32'd1);
      tick();
      chk("drain4_pc", dbg_pc, 32'h110);
      chk("drain4_wdata", dbg_gpr_wdata, 32'd14);
      chk("drain4_done", 32'(dbg_done), 32'd1);
      chk("drain4_count", 32'(count), 32'd0);
      tick();
      chk("drain_idle_done", 32'(dbg_done), 32'd0);

      // x0 write filtered
      drive(1'b1, 32'h200, 32'h0000_0013, 1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, 1'b0);
      tick();
      drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
      tick();
      chk("x0_done", 32'(dbg_done), 32'd1);
      chk("x0_wen", 32'(dbg_gpr_wen), 32'd0);
      chk("x0_pc", dbg_pc, 32'h200);

      // full queue with push and pop offered together, across pointer wrap
      drain_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'h300 + 32'(i) * 4, 32'h13, 1'b1, 5'd7, 32'(i + 20), 1'b0, 1'b0);
         tick();
      end
      drive(1'b1, 32'h310, 32'h13, 1'b1, 5'd7, 32'd24, 1'b0, 1'b0);
      drain_en = 1'b1;
      chk("fullpp_count", 32'(count), 32'd4);
      chk("fullpp_ready", 32'(wbif.wb_ready), 32'd0);
      tick();
      chk("fullpp0_pc", dbg_pc, 32'h300);
      chk("fullpp0_count", 32'(count), 32'd3);
      tick();
      drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
      chk("fullpp1_pc", dbg_pc, 32'h304);
      chk("fullpp1_count", 32'(count), 32'd3);
      tick();
      chk("fullpp2_pc", dbg_pc, 32'h308);
      tick();
      chk("fullpp3_pc", dbg_pc, 32'h30C);
      tick();
      chk("fullpp4_pc", dbg_pc, 32'h310);
      chk("fullpp4_wdata", dbg_gpr_wdata, 32'd24);
      chk("fullpp4_count", 32'(count), 32'd0);
      tick();
      chk("fullpp_idle_done", 32'(dbg_done), 32'd0);

      // break record halts intake
      drain_en = 1'b0;
      drive(1'b1, 32'h400, 32'h0010_0073, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
      tick();
      drive(1'b1, 32'h404, 32'h13, 1'b1, 5'd3, 32'd3, 1'b0, 1'b0);
      chk("brk_halted", 32'(halted), 32'd1);
      chk("brk_ready", 32'(wbif.wb_ready), 32'd0);
      chk("brk_count", 32'(count), 32'd1);
      tick();
      chk("brk_block_count", 32'(count), 32'd1);
      drain_en = 1'b1;
      tick();
      chk("brk_drain_brk", 32'(dbg_brk), 32'd1);
      chk("brk_drain_done", 32'(dbg_done), 32'd1);
      chk("brk_drain_pc", dbg_pc, 32'h400);
      chk("brk_drain_count", 32'(count), 32'd0);
      tick();
      chk("brk_after_count", 32'(count), 32'd0);
      chk("brk_after_done", 32'(dbg_done), 32'd0);
      chk("brk_after_strobe", 32'(dbg_brk), 32'd0);
      chk("brk_after_halted", 32'(halted), 32'd1);
      drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0);

      // reset mid-drain while halted by an invalid instruction
      reset = 1'b1;
      tick();
      reset = 1'b0;
      drain_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'h500 + 32'(i) * 4, 32'h55, 1'b1, 5'd9, 32'(i + 40), 1'b0, i == 3);
         tick();
      end
      drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
      chk("ivd_halted", 32'(halted), 32'd1);
      drain_en = 1'b1;
      tick();
      chk("mid_pc", dbg_pc, 32'h500);
      chk("mid_count", 32'(count), 32'd3);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      drain_en = 1'b0;
      chk("rst2_count", 32'(count), 32'd0);
      chk("rst2_pc", dbg_pc, 32'd0);
      chk("rst2_inst", dbg_inst, 32'd0);
      chk("rst2_done", 32'(dbg_done), 32'd0);
      chk("rst2_waddr", dbg_gpr_waddr, 32'd0);
      chk("rst2_wdata", dbg_gpr_wdata, 32'd0);
      chk("rst2_halted", 32'(halted), 32'd0);
      chk("rst2_ready", 32'(wbif.wb_ready), 32'd1);

      // invalid-instruction strobe on drain
      drain_en = 1'b1;
      drive(1'b1, 32'h600, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
      tick();
      drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
      tick();
      chk("ivd_strobe", 32'(dbg_ivd), 32'd1);
      chk("ivd_brk", 32'(dbg_brk), 32'd0);
      chk("ivd_pc", dbg_pc, 32'h600);
      tick();
      chk("ivd_strobe_fall", 32'(dbg_ivd), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
